// File: rtl/tic_tac_toe_pkg.sv
// Shared types and constants for the tic-tac-toe computer opponent:
// cell codes, winning-line table, corner/edge preference order, FSM states.
package tic_tac_toe_pkg;

    localparam int CELLS = 9;
    localparam int LINES = 8;

    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        PLAYER   = 2'b01,
        COMPUTER = 2'b10,
        TEST     = 2'b11
    } cell_t;

    localparam logic [3:0] LINE_IDX [0:LINES-1][0:2] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    localparam logic [3:0] CENTRE             = 4'd4;
    localparam logic [3:0] CORNER_ORDER [0:3] = '{4'd0, 4'd2, 4'd6, 4'd8};
    localparam logic [3:0] EDGE_ORDER   [0:3] = '{4'd1, 4'd3, 4'd5, 4'd7};

    typedef enum logic [2:0] {
        IDLE,
        SETTLE1,
        SETTLE2,
        SCAN,
        PICK,
        MOVE,
        COOLDOWN
    } state_t;

    function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] board, input logic [3:0] idx);
        return board[2*idx +: 2];
    endfunction

endpackage

// File: rtl/line_eval.sv
// Classifies one winning line: two computer cells plus one empty is a win hit,
// two player cells plus one empty is a block hit (only with COMPUTER_BLOCK_EN).
module line_eval
    import tic_tac_toe_pkg::*;
(
    input  logic [1:0] cell_a,
    input  logic [1:0] cell_b,
    input  logic [1:0] cell_c,
    input  logic [3:0] idx_a,
    input  logic [3:0] idx_b,
    input  logic [3:0] idx_c,
    output logic       win_hit,
`ifdef COMPUTER_BLOCK_EN
    output logic       block_hit,
`endif
    output logic [3:0] empty_idx
);

    logic [1:0] n_comp;
    logic [1:0] n_empty;

    assign n_comp  = 2'(cell_a == COMPUTER) + 2'(cell_b == COMPUTER) + 2'(cell_c == COMPUTER);
    assign n_empty = 2'(cell_a == EMPTY) + 2'(cell_b == EMPTY) + 2'(cell_c == EMPTY);

    assign win_hit = (n_comp == 2'd2) && (n_empty == 2'd1);

`ifdef COMPUTER_BLOCK_EN
    logic [1:0] n_play;
    assign n_play    = 2'(cell_a == PLAYER) + 2'(cell_b == PLAYER) + 2'(cell_c == PLAYER);
    assign block_hit = (n_play == 2'd2) && (n_empty == 2'd1);
`endif

    assign empty_idx = (cell_a == EMPTY) ? idx_a :
                       (cell_b == EMPTY) ? idx_b : idx_c;

endmodule

// File: rtl/computer_player.sv
// Tic-tac-toe opponent: scans the 8 lines after each move and strobes a cell.
// Optional block detection is compiled in with COMPUTER_BLOCK_EN.
//
// state    | meaning
// IDLE     | waiting for player_move / start_computer
// SETTLE1  | board's illegal_move flag is valid
// SETTLE2  | board's win / tie flags are valid
// SCAN     | one winning line per cycle, k = 0..7
// PICK     | choose cell by priority, or pulse no_move
// MOVE     | computer_move strobe
// COOLDOWN | board absorbs the move
module computer_player
    import tic_tac_toe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [2*CELLS-1:0]   board_state,
    input  logic                 player_move,
    input  logic                 start_computer,
    input  logic                 illegal_move,
    input  logic                 win,
    input  logic                 tie,
    output logic                 computer_move,
    output logic [3:0]           computer_address,
    output logic                 busy,
    output logic                 no_move
);

    state_t                       state, state_nxt;
    logic [$clog2(LINES)-1:0]     k;
    logic                         win_found;
    logic [3:0]                   win_idx;
    logic                         line_win;
    logic [3:0]                   line_empty;
    logic                         pick_found;
    logic [3:0]                   pick_idx;
`ifdef COMPUTER_BLOCK_EN
    logic                         blk_found;
    logic [3:0]                   blk_idx;
    logic                         line_block;
`endif

    line_eval u_line_eval (
        .cell_a    (cell_at(board_state, LINE_IDX[k][0])),
        .cell_b    (cell_at(board_state, LINE_IDX[k][1])),
        .cell_c    (cell_at(board_state, LINE_IDX[k][2])),
        .idx_a     (LINE_IDX[k][0]),
        .idx_b     (LINE_IDX[k][1]),
        .idx_c     (LINE_IDX[k][2]),
        .win_hit   (line_win),
`ifdef COMPUTER_BLOCK_EN
        .block_hit (line_block),
`endif
        .empty_idx (line_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (player_move)         state_nxt = SETTLE1;
                else if (start_computer) state_nxt = SCAN;
            end
            SETTLE1:  state_nxt = illegal_move ? IDLE : SETTLE2;
            SETTLE2:  state_nxt = (win || tie) ? IDLE : SCAN;
            SCAN:     if (k == 3'(LINES - 1)) state_nxt = PICK;
            PICK:     state_nxt = pick_found ? MOVE : IDLE;
            MOVE:     state_nxt = COOLDOWN;
            COOLDOWN: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        computer_move = (state == MOVE);
        busy          = (state != IDLE);
        no_move       = (state == PICK) && !pick_found;
    end

    // First hit of each kind wins; flags are cleared while idle so every scan starts fresh.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k         <= '0;
            win_found <= 1'b0;
            win_idx   <= 4'd0;
`ifdef COMPUTER_BLOCK_EN
            blk_found <= 1'b0;
            blk_idx   <= 4'd0;
`endif
        end else if (state == SCAN) begin
            k <= k + 1'b1;
            if (line_win && !win_found) begin
                win_found <= 1'b1;
                win_idx   <= line_empty;
            end
`ifdef COMPUTER_BLOCK_EN
            if (line_block && !blk_found) begin
                blk_found <= 1'b1;
                blk_idx   <= line_empty;
            end
`endif
        end else if (state == IDLE) begin
            k         <= '0;
            win_found <= 1'b0;
            win_idx   <= 4'd0;
`ifdef COMPUTER_BLOCK_EN
            blk_found <= 1'b0;
            blk_idx   <= 4'd0;
`endif
        end
    end

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 4'd0;
        if (win_found) begin
            pick_found = 1'b1;
            pick_idx   = win_idx;
        end
`ifdef COMPUTER_BLOCK_EN
        else if (blk_found) begin
            pick_found = 1'b1;
            pick_idx   = blk_idx;
        end
`endif
        else if (cell_at(board_state, CENTRE) == EMPTY) begin
            pick_found = 1'b1;
            pick_idx   = CENTRE;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!pick_found && cell_at(board_state, CORNER_ORDER[i]) == EMPTY) begin
                    pick_found = 1'b1;
                    pick_idx   = CORNER_ORDER[i];
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (!pick_found && cell_at(board_state, EDGE_ORDER[i]) == EMPTY) begin
                    pick_found = 1'b1;
                    pick_idx   = EDGE_ORDER[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                          computer_address <= 4'd0;
        else if (state == PICK && pick_found) computer_address <= pick_idx;
    end

endmodule
